// File: rtl/shake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shake_pkg
// Description : Shared constants and dump FSM state encoding for the SHAKE
//               squeeze path.
// Revision    : 1.0 - initial release
// ============================================================================
package shake_pkg;

    localparam int WORD_WIDTH          = 64;
    localparam int SHAKE128_RATE_WORDS = 21;
    localparam int SHAKE256_RATE_WORDS = 17;

    typedef enum logic [2:0] {
        WAIT_HEADER = 3'd0,
        WAIT_BUFFER = 3'd1,
        DUMP        = 3'd2,
        RELEASE     = 3'd3,
        WAIT_CLEAR  = 3'd4
    } dump_state_t;

    // Index of the last word of a rate block: mode 0 = SHAKE128, 1 = SHAKE256.
    function automatic logic [4:0] rate_last_word(input logic mode);
        return mode ? 5'(SHAKE256_RATE_WORDS - 1) : 5'(SHAKE128_RATE_WORDS - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dump_counter.sv
`default_nettype none
// ============================================================================
// Module      : dump_counter
// Description : Remaining-bits down-counter with last-word detect and
//               valid-bit count of the final word.
// Revision    : 1.0 - initial release
// ============================================================================
module dump_counter
    import shake_pkg::*;
#(
    parameter int LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [LEN_WIDTH-1:0] i_load_value,
    input  logic                 i_decrement,
    output logic                 o_last_word,
    output logic [5:0]           o_last_word_bits
);

    localparam logic [LEN_WIDTH-1:0] c_word_bits = LEN_WIDTH'(WORD_WIDTH);

    logic [LEN_WIDTH-1:0] r_remaining;

    // Saturating step of min(64, remaining) so the count cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_value;
        end else if (i_decrement) begin
            r_remaining <= (r_remaining > c_word_bits) ? (r_remaining - c_word_bits) : '0;
        end
    end

    assign o_last_word      = (r_remaining <= c_word_bits);
    assign o_last_word_bits = r_remaining[5:0];

endmodule
`default_nettype wire

// File: rtl/dump_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dump_fsm
// Description : Streams squeezed SHAKE output words from the PISO, requesting
//               refills per rate block until the requested length is sent.
// Revision    : 1.0 - initial release
// ============================================================================
module dump_fsm
    import shake_pkg::*;
#(
    parameter int LEN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 header_valid,
    input  logic [LEN_WIDTH-1:0] output_length,
    input  logic                 mode,
    input  logic                 output_buffer_ready,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic                 last_out,
    output logic [5:0]           last_word_bits,
    output logic                 shift_enable,
    output logic                 output_buffer_consumed_wr,
    output logic                 squeeze_request,
    output logic                 done_out
);

    dump_state_t r_state;
    logic [4:0]  r_word_cnt;
    logic        r_mode;
    logic        r_final;
    logic        r_zero_done;

    logic        w_load;
    logic        w_last_word;
    logic [5:0]  w_last_bits;
    logic        w_in_dump;
    logic [4:0]  w_rate_last;

    assign w_in_dump   = (r_state == DUMP);
    assign w_load      = (r_state == WAIT_HEADER) && header_valid;
    assign w_rate_last = rate_last_word(r_mode);

    dump_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_dump_counter (
        .clk              (clk),
        .rst              (rst),
        .i_load           (w_load),
        .i_load_value     (output_length),
        .i_decrement      (shift_enable),
        .o_last_word      (w_last_word),
        .o_last_word_bits (w_last_bits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= WAIT_HEADER;
            r_word_cnt  <= 5'd0;
            r_mode      <= 1'b0;
            r_final     <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            case (r_state)
                WAIT_HEADER: begin
                    if (header_valid) begin
                        r_mode <= mode;
                        if (output_length == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_state <= WAIT_BUFFER;
                        end
                    end
                end
                WAIT_BUFFER: begin
                    r_word_cnt <= 5'd0;
                    if (output_buffer_ready) begin
                        r_state <= DUMP;
                    end
                end
                DUMP: begin
                    if (ready_in) begin
                        // End of output takes precedence over end of block.
                        if (w_last_word || (r_word_cnt == w_rate_last)) begin
                            r_final    <= w_last_word;
                            r_word_cnt <= 5'd0;
                            r_state    <= RELEASE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 5'd1;
                        end
                    end
                end
                RELEASE: begin
                    r_state <= WAIT_CLEAR;
                end
                WAIT_CLEAR: begin
                    if (!output_buffer_ready) begin
                        r_state <= r_final ? WAIT_HEADER : WAIT_BUFFER;
                    end
                end
                default: begin
                    r_state <= WAIT_HEADER;
                end
            endcase
        end
    end

    assign valid_out                 = w_in_dump;
    assign last_out                  = w_in_dump && w_last_word;
    assign last_word_bits            = last_out ? w_last_bits : 6'd0;
    assign shift_enable              = w_in_dump && ready_in;
    assign output_buffer_consumed_wr = (r_state == RELEASE);
    assign squeeze_request           = (r_state == RELEASE) && !r_final;
    assign done_out                  = r_zero_done || ((r_state == RELEASE) && r_final);

endmodule
`default_nettype wire

// File: tb/tb_dump_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dump_fsm
// Description : Self-checking bench for dump_fsm with a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dump_fsm;

    localparam int LW = 32;

    logic          clk;
    logic          rst;
    logic          header_valid;
    logic [LW-1:0] output_length;
    logic          mode;
    logic          output_buffer_ready;
    logic          ready_in;
    logic          valid_out;
    logic          last_out;
    logic [5:0]    last_word_bits;
    logic          shift_enable;
    logic          output_buffer_consumed_wr;
    logic          squeeze_request;
    logic          done_out;

    dump_fsm #(.LEN_WIDTH(LW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .header_valid              (header_valid),
        .output_length             (output_length),
        .mode                      (mode),
        .output_buffer_ready       (output_buffer_ready),
        .ready_in                  (ready_in),
        .valid_out                 (valid_out),
        .last_out                  (last_out),
        .last_word_bits            (last_word_bits),
        .shift_enable              (shift_enable),
        .output_buffer_consumed_wr (output_buffer_consumed_wr),
        .squeeze_request           (squeeze_request),
        .done_out                  (done_out)
    );

    typedef struct {
        logic       last;
        logic [5:0] bits;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_accepted, n_consumed, n_squeeze, n_done;
    bit   buf_empty = 1'b1;
    bit   ready_pending = 1'b0;
    int   ready_age = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer and handshake counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                check("valid_while_empty", {31'd0, buf_empty}, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    check("last_out", {31'd0, last_out}, {31'd0, exp_q[0].last});
                    check("last_word_bits", {26'd0, last_word_bits}, {26'd0, exp_q[0].bits});
                    check("shift_enable", {31'd0, shift_enable}, {31'd0, ready_in});
                    if (shift_enable) begin
                        void'(exp_q.pop_front());
                        n_accepted++;
                    end
                end
            end else begin
                check("shift_idle", {31'd0, shift_enable}, 0);
            end
            if (output_buffer_consumed_wr) n_consumed++;
            if (squeeze_request)           n_squeeze++;
            if (done_out)                  n_done++;
            if (ready_pending) begin
                if (ready_age == 0) begin
                    check("first_valid_early", {31'd0, valid_out}, 0);
                end else begin
                    check("first_valid_latency", {31'd0, valid_out}, 1);
                    ready_pending = 1'b0;
                end
                ready_age++;
            end
        end
    end

    function automatic logic [31:0] all_outputs();
        return {19'd0, valid_out, last_out, last_word_bits, shift_enable,
                output_buffer_consumed_wr, squeeze_request, done_out};
    endfunction

    task automatic run_request(input int len, input bit m, input int stall_word,
                               input int stall_cycles, input int abort_word);
        int   rem;
        int   words;
        int   rate;
        int   blocks;
        int   stall_left;
        int   refill;
        bit   fin;
        bit   aborted;
        exp_t e;

        exp_q.delete();
        rem   = len;
        words = 0;
        while (rem > 0) begin
            e.last = (rem <= 64);
            e.bits = (rem <= 64) ? 6'(rem % 64) : 6'd0;
            exp_q.push_back(e);
            words++;
            rem -= (rem > 64) ? 64 : rem;
        end
        rate       = m ? 17 : 21;
        blocks     = (words + rate - 1) / rate;
        n_accepted = 0;
        n_consumed = 0;
        n_squeeze  = 0;
        n_done     = 0;
        stall_left = stall_cycles;
        fin        = 1'b0;
        aborted    = 1'b0;

        @(posedge clk); #1;
        header_valid  = 1'b1;
        output_length = LW'(len);
        mode          = m;
        @(posedge clk); #1;
        // Conflicting header held high for the whole transfer must be ignored.
        output_length = LW'(7);
        mode          = ~m;
        refill        = 2;

        for (int cyc = 0; cyc < 3000 && !fin && !aborted; cyc++) begin
            if (output_buffer_consumed_wr) begin
                output_buffer_ready = 1'b0;
                buf_empty           = 1'b1;
                if (squeeze_request) refill = 3;
                if (done_out) begin
                    fin          = 1'b1;
                    header_valid = 1'b0;
                end
            end else if (refill > 0) begin
                refill--;
                if (refill == 0) begin
                    output_buffer_ready = 1'b1;
                    buf_empty           = 1'b0;
                    ready_pending       = 1'b1;
                    ready_age           = 0;
                end
            end
            ready_in = !(valid_out && (n_accepted == stall_word - 1) && (stall_left > 0));
            if (!ready_in) stall_left--;
            if (abort_word > 0 && valid_out && n_accepted == abort_word - 1) begin
                rst = 1'b1;
                #1;
                check("reset_mid_dump_outputs", all_outputs(), 0);
                header_valid        = 1'b0;
                output_buffer_ready = 1'b0;
                buf_empty           = 1'b1;
                ready_pending       = 1'b0;
                ready_in            = 1'b1;
                exp_q.delete();
                @(posedge clk); #1;
                check("reset_held_outputs", all_outputs(), 0);
                rst     = 1'b0;
                aborted = 1'b1;
            end else if (!fin) begin
                @(posedge clk); #1;
            end
        end
        header_valid = 1'b0;
        ready_in     = 1'b1;

        if (abort_word > 0) begin
            check("abort_reached", {31'd0, aborted}, 1);
        end else begin
            check("completed_in_budget", {31'd0, fin}, 1);
            repeat (3) @(posedge clk);
            #1;
            check("words_accepted", n_accepted, words);
            check("words_left", exp_q.size(), 0);
            check("consumed_pulses", n_consumed, blocks);
            check("squeeze_pulses", n_squeeze, blocks - 1);
            check("done_pulses", n_done, 1);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        header_valid        = 1'b0;
        output_length       = '0;
        mode                = 1'b0;
        output_buffer_ready = 1'b0;
        ready_in            = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_request(256, 1'b0, 0, 0, 0);
        run_request(1088, 1'b1, 0, 0, 0);
        run_request(1400, 1'b0, 0, 0, 0);
        run_request(640, 1'b1, 7, 5, 0);

        // Zero-length request: a lone done pulse, no data or handshakes.
        n_consumed = 0;
        n_accepted = 0;
        @(posedge clk); #1;
        header_valid  = 1'b1;
        output_length = '0;
        @(negedge clk);
        check("zero_len_done_early", {31'd0, done_out}, 0);
        @(posedge clk); #1;
        header_valid = 1'b0;
        @(negedge clk);
        check("zero_len_done", {31'd0, done_out}, 1);
        check("zero_len_valid", {31'd0, valid_out}, 0);
        @(negedge clk);
        check("zero_len_done_width", {31'd0, done_out}, 0);
        repeat (3) @(negedge clk);
        check("zero_len_consumed", n_consumed, 0);
        check("zero_len_words", n_accepted, 0);

        run_request(1344, 1'b0, 0, 0, 10);
        run_request(64, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dump_fsm.md
DUMP_FSM -- requirements
Module: dump_fsm

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 32, giving the width of the output-length field in bits.
REQ-002 SHALL have input clk, 1 bit: system clock, rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have input header_valid, 1 bit: header word present; latches output_length and mode.
REQ-005 SHALL have input output_length, LEN_WIDTH bits: requested squeeze length in bits.
REQ-006 SHALL have input mode, 1 bit: 0 = SHAKE128 (rate 21 words), 1 = SHAKE256 (rate 17 words).
REQ-007 SHALL have input output_buffer_ready, 1 bit: producer handshake; PISO holds a fresh rate block.
REQ-008 SHALL have input ready_in, 1 bit: downstream accepts the current word.
REQ-009 SHALL have output valid_out, 1 bit: PISO head word is valid.
REQ-010 SHALL have output last_out, 1 bit: current word is the final word of the output.
REQ-011 SHALL have output last_word_bits, 6 bits: valid bits in the final word; 0 means 64.
REQ-012 SHALL have output shift_enable, 1 bit: advance the PISO by one 64-bit word.
REQ-013 SHALL have output output_buffer_consumed_wr, 1 bit: handshake; buffer emptied, producer clears its ready flag.
REQ-014 SHALL have output squeeze_request, 1 bit: producer must permute and refill.
REQ-015 SHALL have output done_out, 1 bit: one-cycle pulse when the request completes.

Function
REQ-016 SHALL implement states WAIT_HEADER, WAIT_BUFFER, DUMP, RELEASE, WAIT_CLEAR.
REQ-017 In WAIT_HEADER, header_valid=1 SHALL latch remaining=output_length and rate=mode; go to WAIT_BUFFER if length nonzero.
REQ-018 In WAIT_HEADER, header_valid=1 with output_length=0 SHALL pulse done_out, stay in WAIT_HEADER, and emit no valid_out, shift or handshake.
REQ-019 In WAIT_BUFFER, word_cnt SHALL be held at 0; output_buffer_ready=1 SHALL move the FSM to DUMP.
REQ-020 In DUMP, valid_out SHALL be 1; first valid_out SHALL occur exactly one cycle after ready is seen in WAIT_BUFFER.
REQ-021 On valid_out and ready_in in DUMP, SHALL assert shift_enable the same cycle, increment word_cnt, and decrement remaining by min(64, remaining).
REQ-022 In DUMP with ready_in=0, all counters SHALL hold and valid_out SHALL stay 1; valid_out SHALL never drop before acceptance.
REQ-023 last_out SHALL be 1 in DUMP iff remaining <= 64.
REQ-024 last_word_bits SHALL equal remaining[5:0] when last_out=1, else 0.
REQ-025 An accepted word with last_out=1, or with word_cnt = rate-1, SHALL move the FSM to RELEASE.
REQ-026 If both conditions of REQ-025 coincide, the transfer SHALL be treated as final.
REQ-027 RELEASE SHALL last exactly one cycle and assert output_buffer_consumed_wr.
REQ-028 RELEASE SHALL assert squeeze_request iff the transfer was not final.
REQ-029 On a final transfer, RELEASE SHALL also assert done_out.
REQ-030 WAIT_CLEAR SHALL hold until output_buffer_ready=0, guarding against a stale ready flag.
REQ-031 WAIT_CLEAR SHALL then go to WAIT_HEADER if final, else WAIT_BUFFER.
REQ-032 header_valid SHALL be ignored outside WAIT_HEADER.
REQ-033 remaining SHALL never underflow.
REQ-034 word_cnt SHALL be 5 bits and SHALL never exceed rate-1.
REQ-035 All outputs SHALL be combinational from state and registers only; no input-to-output path except shift_enable from ready_in.

Reset
REQ-036 rst SHALL force state WAIT_HEADER and clear remaining, word_cnt, the rate register and the final flag.
REQ-037 rst SHALL force every output to 0, including when asserted mid-DUMP or in RELEASE.

Structure
REQ-038 SHALL place the state enum and constants WORD_WIDTH=64, SHAKE128_RATE_WORDS=21 and SHAKE256_RATE_WORDS=17 in shared package shake_pkg.
REQ-039 SHALL use one sub-module, dump_counter: the remaining-bits down-counter with last-word detect and last_word_bits generation.

Verification
REQ-040 SHALL test mode=0, length=256: 4 words, last_out on word 4, last_word_bits=0, one consumed pulse, no squeeze_request, done_out.
REQ-041 SHALL test mode=1, length=1088: exactly 17 words, last_out on word 17, squeeze_request never asserted.
REQ-042 SHALL test mode=0, length=1400: 21 words, then RELEASE with squeeze_request, then WAIT_CLEAR, then 1 word with last_word_bits=56.
REQ-043 SHALL test ready_in low for 5 cycles at word 7: valid_out held, no shift, counters frozen, and the stream resumes intact.
REQ-044 SHALL test length=0: done_out pulse one cycle after header_valid, no valid_out, no consumed pulse.
REQ-045 SHALL test rst asserted at word 10 of DUMP: all outputs 0 immediately, and a new header of length 64 yields exactly 1 word.
